// File: rtl/trans_seq_ctrl.sv
// ============================================================================
// Module   : trans_seq_ctrl
// Purpose  : Round-robin shared engine emitting trans, start_trans, a, b, c, end_trans.
// Options  : TRANS_SEQ_CTRL_ASSERT_EN enables protocol assertions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module trans_seq_ctrl #(
  parameter  int NUM_REQ = 2,
  parameter  int GAP     = 1,
  parameter  int CNT_W   = 16,
  localparam int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [OWN_W-1:0]   owner,
  output logic               trans,
  output logic               start_trans,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               end_trans,
  output logic               busy,
  output logic [CNT_W-1:0]   txn_count
);

  localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRANS = 3'd1,
    S_START = 3'd2,
    S_A     = 3'd3,
    S_B     = 3'd4,
    S_C     = 3'd5,
    S_END   = 3'd6,
    S_GAP   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [OWN_W-1:0] owner_q, owner_d;
  logic [OWN_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [GAP_W-1:0] gap_q,   gap_d;

  logic             win_valid;
  logic [OWN_W-1:0] win_idx;
  int               idx;

  // Scan starts just after the last winner, so that winner ends up lowest priority.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last_q;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_valid && req[OWN_W'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = OWN_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          state_d = S_TRANS;
          owner_d = win_idx;
          last_d  = win_idx;
        end
      end
      S_TRANS: state_d = S_START;
      S_START: state_d = S_A;
      S_A:     state_d = S_B;
      S_B:     state_d = S_C;
      S_C:     state_d = S_END;
      S_END: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= OWN_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Strobes decode only the state register, so req has no combinational path out.
  logic [5:0] strb;
  logic       in_txn;

  assign strb = {state_q == S_TRANS, state_q == S_START, state_q == S_A,
                 state_q == S_B,     state_q == S_C,     state_q == S_END};
  assign in_txn = |strb;

  assign {trans, start_trans, a, b, c, end_trans} = strb;
  assign gnt       = in_txn ? (NUM_REQ'(1) << owner_q) : '0;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);
  assign txn_count = cnt_q;

`ifdef TRANS_SEQ_CTRL_ASSERT_EN
  a_seq: assert property (@(posedge sysclk) disable iff (rst)
    trans |-> ##1 start_trans ##1 a ##1 b ##1 c ##1 end_trans)
    else $error("trans_seq_ctrl: phase sequence broken");

  a_strb_onehot: assert property (@(posedge sysclk) disable iff (rst) $onehot0(strb))
    else $error("trans_seq_ctrl: more than one strobe high");

  a_gnt_onehot: assert property (@(posedge sysclk) disable iff (rst) $onehot0(gnt))
    else $error("trans_seq_ctrl: grant not one-hot");

  a_gnt_stable: assert property (@(posedge sysclk) disable iff (rst)
    (start_trans | a | b | c | end_trans) |-> $stable(gnt))
    else $error("trans_seq_ctrl: grant changed mid-transaction");

  a_gnt_rise: assert property (@(posedge sysclk) disable iff (rst) $rose(|gnt) |-> trans)
    else $error("trans_seq_ctrl: grant rose outside trans");
`else
  // Assertions compiled out; datapath unchanged.
`endif

endmodule

`default_nettype wire

// File: tb/tb_trans_seq_ctrl.sv
// ============================================================================
// Module   : tb_trans_seq_ctrl
// Purpose  : Scoreboard bench for trans_seq_ctrl (default and CNT_W=2/GAP=0 builds).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trans_seq_ctrl;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       rst;
  logic [1:0] req, req2;

  logic [1:0]  gnt1, gnt2;
  logic        owner1, owner2;
  logic        tr1, st1, a1, b1, c1, e1, busy1;
  logic        tr2, st2, a2, b2, c2, e2, busy2;
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  trans_seq_ctrl #(.NUM_REQ(2), .GAP(1), .CNT_W(16)) dut (
    .sysclk(sysclk), .rst(rst), .req(req), .gnt(gnt1), .owner(owner1),
    .trans(tr1), .start_trans(st1), .a(a1), .b(b1), .c(c1), .end_trans(e1),
    .busy(busy1), .txn_count(cnt1));

  trans_seq_ctrl #(.NUM_REQ(2), .GAP(0), .CNT_W(2)) dut2 (
    .sysclk(sysclk), .rst(rst), .req(req2), .gnt(gnt2), .owner(owner2),
    .trans(tr2), .start_trans(st2), .a(a2), .b(b2), .c(c2), .end_trans(e2),
    .busy(busy2), .txn_count(cnt2));

  localparam logic [35:0] SEQ_EXP = {6'b100000, 6'b010000, 6'b001000,
                                     6'b000100, 6'b000010, 6'b000001};

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int         owner;
    logic [1:0] gnt;
    int         cnt;
  } exp_t;
  exp_t sb[$];

  // Observation mux: sel=0 watches dut, sel=1 watches dut2.
  logic       sel = 1'b0;
  logic [5:0] m_strb;
  logic [1:0] m_gnt;
  logic       m_busy;
  int         m_owner, m_cnt;
  always_comb begin
    if (sel) begin
      m_strb = {tr2, st2, a2, b2, c2, e2}; m_gnt = gnt2; m_busy = busy2;
      m_owner = int'(owner2); m_cnt = int'(cnt2);
    end else begin
      m_strb = {tr1, st1, a1, b1, c1, e1}; m_gnt = gnt1; m_busy = busy1;
      m_owner = int'(owner1); m_cnt = int'(cnt1);
    end
  end

  // Waits (bounded) for trans, then records the six phases and the cycle after end_trans.
  task automatic capture(output bit to, output int t0, output logic [35:0] seq,
                         output logic [1:0] g0, output int own, output bit gnt_stable,
                         output bit busy_all, output int cnt_after,
                         output logic busy_after, output logic [1:0] gnt_after);
    int n = 0;
    to = 1'b0; t0 = 0; seq = '0; g0 = '0; own = -1; gnt_stable = 1'b0;
    busy_all = 1'b0; cnt_after = -1; busy_after = 1'bx; gnt_after = 'x;
    while (m_strb[5] !== 1'b1 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    if (m_strb[5] !== 1'b1) begin
      to = 1'b1;
      return;
    end
    t0 = cyc; g0 = m_gnt; own = m_owner; gnt_stable = 1'b1; busy_all = 1'b1;
    for (int p = 0; p < 6; p++) begin
      if (p > 0) @(negedge sysclk);
      seq = {seq[29:0], m_strb};
      if (m_gnt !== g0) gnt_stable = 1'b0;
      if (m_busy !== 1'b1) busy_all = 1'b0;
    end
    @(negedge sysclk);
    cnt_after = m_cnt; busy_after = m_busy; gnt_after = m_gnt;
  endtask

  bit          to, gs, ba;
  int          t0, own, cnt_a, t_prev;
  logic [35:0] seq;
  logic [1:0]  g0, g_a;
  logic        b_a;
  exp_t        e;

  task automatic test_reset();
    rst = 1'b1; req = '0; req2 = '0;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      total_cnt++;
      if ({tr1, st1, a1, b1, c1, e1, gnt1, busy1, owner1, cnt1,
           tr2, st2, a2, b2, c2, e2, gnt2, busy2, owner2, cnt2} !== '0)
        $display("FAIL reset_idle[%0d]: dut1 strb=%b gnt=%b busy=%b own=%0d cnt=%0d dut2 strb=%b cnt=%0d, all required 0",
                 i, {tr1, st1, a1, b1, c1, e1}, gnt1, busy1, owner1, cnt1,
                 {tr2, st2, a2, b2, c2, e2}, cnt2);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int c_set;
    sel = 1'b0;
    c_set = cyc;
    req = 2'b01;
    sb.push_back('{0, 2'b01, 1});
    sb.push_back('{0, 2'b01, 2});
    capture(to, t0, seq, g0, own, gs, ba, cnt_a, b_a, g_a);
    e = sb.pop_front();
    total_cnt++; if (to !== 1'b0) $display("FAIL single_timeout: no trans seen"); else pass_cnt++;
    total_cnt++; if (t0 !== c_set + 1) $display("FAIL single_latency: trans cycle %0d, required %0d", t0, c_set + 1); else pass_cnt++;
    total_cnt++; if (seq !== SEQ_EXP) $display("FAIL single_seq: got %h required %h", seq, SEQ_EXP); else pass_cnt++;
    total_cnt++; if (g0 !== e.gnt || gs !== 1'b1) $display("FAIL single_gnt: gnt=%b stable=%0d, required %b stable", g0, gs, e.gnt); else pass_cnt++;
    total_cnt++; if (ba !== 1'b1) $display("FAIL single_busy: busy dropped during phases"); else pass_cnt++;
    total_cnt++; if (cnt_a !== e.cnt) $display("FAIL single_count: got %0d required %0d", cnt_a, e.cnt); else pass_cnt++;
    total_cnt++; if (b_a !== 1'b1 || g_a !== 2'b00) $display("FAIL single_gap: busy=%b gnt=%b, required busy=1 gnt=00", b_a, g_a); else pass_cnt++;
    t_prev = t0;
    capture(to, t0, seq, g0, own, gs, ba, cnt_a, b_a, g_a);
    req = 2'b00;
    e = sb.pop_front();
    total_cnt++; if (t0 !== t_prev + 8) $display("FAIL single_spacing: next trans %0d, required %0d", t0, t_prev + 8); else pass_cnt++;
    total_cnt++; if (cnt_a !== e.cnt || own !== e.owner) $display("FAIL single_second: cnt=%0d own=%0d, required cnt=%0d own=%0d", cnt_a, own, e.cnt, e.owner); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    sel = 1'b0;
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    req = 2'b11;
    for (int k = 0; k < 4; k++) sb.push_back('{k % 2, (k % 2 == 0) ? 2'b01 : 2'b10, k + 1});
    for (int k = 0; k < 4; k++) begin
      capture(to, t0, seq, g0, own, gs, ba, cnt_a, b_a, g_a);
      e = sb.pop_front();
      total_cnt++;
      if (to !== 1'b0 || seq !== SEQ_EXP || own !== e.owner || g0 !== e.gnt || gs !== 1'b1 || cnt_a !== e.cnt)
        $display("FAIL rr[%0d]: to=%0d seq=%h own=%0d gnt=%b cnt=%0d, required own=%0d gnt=%b cnt=%0d",
                 k, to, seq, own, g0, cnt_a, e.owner, e.gnt, e.cnt);
      else pass_cnt++;
    end
    req = 2'b00;
  endtask

  task automatic test_pulse();
    int extra = 0;
    sel = 1'b0;
    repeat (3) @(negedge sysclk);
    req = 2'b01;
    sb.push_back('{0, 2'b01, 5});
    @(negedge sysclk);
    req = 2'b00;
    capture(to, t0, seq, g0, own, gs, ba, cnt_a, b_a, g_a);
    e = sb.pop_front();
    total_cnt++;
    if (to !== 1'b0 || seq !== SEQ_EXP || own !== e.owner || g0 !== e.gnt || cnt_a !== e.cnt)
      $display("FAIL pulse_txn: to=%0d seq=%h own=%0d gnt=%b cnt=%0d, required own=%0d gnt=%b cnt=%0d",
               to, seq, own, g0, cnt_a, e.owner, e.gnt, e.cnt);
    else pass_cnt++;
    for (int i = 0; i < 15; i++) begin
      @(negedge sysclk);
      if (tr1 === 1'b1) extra++;
    end
    total_cnt++; if (extra !== 0) $display("FAIL pulse_no_second: %0d extra trans, required 0", extra); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n = 0, ends = 0;
    sel = 1'b0;
    req = 2'b01;
    while (tr1 !== 1'b1 && n < 20) begin
      @(negedge sysclk);
      n++;
    end
    repeat (2) @(negedge sysclk);
    total_cnt++; if (a1 !== 1'b1) $display("FAIL rstmid_phase_a: a=%b required 1", a1); else pass_cnt++;
    rst = 1'b1; req = 2'b00;
    @(negedge sysclk);
    total_cnt++;
    if ({tr1, st1, a1, b1, c1, e1, gnt1, busy1, owner1, cnt1} !== '0)
      $display("FAIL rstmid_clear: strb=%b gnt=%b busy=%b own=%0d cnt=%0d, required all 0",
               {tr1, st1, a1, b1, c1, e1}, gnt1, busy1, owner1, cnt1);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sysclk);
      if (e1 === 1'b1) ends++;
    end
    total_cnt++; if (ends !== 0) $display("FAIL rstmid_no_end: %0d end_trans, required 0", ends); else pass_cnt++;
    req = 2'b01;
    sb.push_back('{0, 2'b01, 1});
    capture(to, t0, seq, g0, own, gs, ba, cnt_a, b_a, g_a);
    req = 2'b00;
    e = sb.pop_front();
    total_cnt++;
    if (to !== 1'b0 || seq !== SEQ_EXP || own !== e.owner || g0 !== e.gnt || cnt_a !== e.cnt)
      $display("FAIL rstmid_restart: to=%0d seq=%h own=%0d gnt=%b cnt=%0d, required own=%0d gnt=%b cnt=%0d",
               to, seq, own, g0, cnt_a, e.owner, e.gnt, e.cnt);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    sel = 1'b1;
    repeat (3) @(negedge sysclk);
    req2 = 2'b01;
    for (int k = 0; k < 5; k++) sb.push_back('{0, 2'b01, (k + 1) % 4});
    for (int k = 0; k < 5; k++) begin
      capture(to, t0, seq, g0, own, gs, ba, cnt_a, b_a, g_a);
      e = sb.pop_front();
      total_cnt++;
      if (to !== 1'b0 || seq !== SEQ_EXP || cnt_a !== e.cnt || g0 !== e.gnt)
        $display("FAIL wrap[%0d]: to=%0d seq=%h gnt=%b cnt=%0d, required gnt=%b cnt=%0d",
                 k, to, seq, g0, cnt_a, e.gnt, e.cnt);
      else pass_cnt++;
      if (k > 0) begin
        total_cnt++;
        if (t0 !== t_prev + 7)
          $display("FAIL wrap_spacing[%0d]: trans at %0d, required %0d", k, t0, t_prev + 7);
        else pass_cnt++;
      end
      t_prev = t0;
    end
    req2 = 2'b00;
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pulse();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100us");
    $fatal(1);
  end

endmodule

`default_nettype wire
